// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: access size codes,
// sequencer states, requester port ids and the address legality rule.
package dm_arbiter_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_X = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  // An access is legal when its size code exists, it is naturally aligned
  // and its byte address falls inside the 2^addr_w word array.
  function automatic logic is_legal(input logic [1:0] size,
                                    input logic [31:0] addr,
                                    input int unsigned addr_w);
    logic ok;
    ok = 1'b1;
    if (size == SZ_X) ok = 1'b0;
    if (size == SZ_H && addr[0]) ok = 1'b0;
    if (size == SZ_W && addr[1:0] != 2'b00) ok = 1'b0;
    if ((addr >> (addr_w + 2)) != 32'd0) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/dm_arbiter_if.sv
// One requester's request/response bundle. The requester drives the
// master side; the arbiter takes the slave side.
interface dm_arbiter_if;
  logic        valid;
  logic        ready;
  logic        we;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (output valid, we, size, addr, wdata,
                  input  ready, rvalid, rdata, err);
  modport slave  (input  valid, we, size, addr, wdata,
                  output ready, rvalid, rdata, err);
endinterface

// File: rtl/dm_lane_merge.sv
// Replaces the addressed byte/half lane of an existing word with
// right-aligned store data; other lanes pass through untouched.
module dm_lane_merge
  import dm_arbiter_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] new_data,
  input  logic [1:0]  size,
  input  logic [1:0]  byte_off,
  output logic [31:0] merged
);

  // Overlay the new lane on the old word.
  // NOTE: merged is given a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    merged = old_word;
    case (size)
      SZ_B: begin
        case (byte_off)
          2'd0: merged[7:0]   = new_data[7:0];
          2'd1: merged[15:8]  = new_data[7:0];
          2'd2: merged[23:16] = new_data[7:0];
          default: merged[31:24] = new_data[7:0];
        endcase
      end
      SZ_H: begin
        if (byte_off[1]) merged[31:16] = new_data[15:0];
        else             merged[15:0]  = new_data[15:0];
      end
      SZ_W: merged = new_data;
      default: merged = old_word;
    endcase
  end

endmodule

// File: rtl/dm_arbiter.sv
// Two-port arbiter and access sequencer for the single-ported data memory.
// One transaction in flight; sub-word stores run as read-modify-write.
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  dm_arbiter_if.slave       p0,
  dm_arbiter_if.slave       p1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_e            state_q, state_d;
  port_e             last_grant_q, id_q, winner;
  logic              we_q, err_q;
  logic [1:0]        size_q;
  logic [ADDR_W+1:0] addr_q;
  logic [31:0]       wdata_q, rdata_q, merged;

  logic              any_valid, accept, req_legal, req_we, done;
  logic [1:0]        req_size;
  logic [31:0]       req_addr, req_wdata;

  // Choose the winner: a lone valid port, or on a tie the port not granted last.
  always_comb begin
    winner = PORT0;
    if (p0.valid && p1.valid) winner = (last_grant_q == PORT0) ? PORT1 : PORT0;
    else if (p1.valid)        winner = PORT1;
  end

  assign any_valid = p0.valid | p1.valid;
  assign accept    = (state_q == ST_IDLE) && any_valid && !reset;
  assign p0.ready  = accept && (winner == PORT0);
  assign p1.ready  = accept && (winner == PORT1);

  assign req_we    = (winner == PORT1) ? p1.we    : p0.we;
  assign req_size  = (winner == PORT1) ? p1.size  : p0.size;
  assign req_addr  = (winner == PORT1) ? p1.addr  : p0.addr;
  assign req_wdata = (winner == PORT1) ? p1.wdata : p0.wdata;
  assign req_legal = is_legal(req_size, req_addr, ADDR_W);

  // Sequence one access: illegal requests skip straight to completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = req_legal ? ST_ACCESS : ST_DONE;
      ST_ACCESS: state_d = (we_q && size_q != SZ_W) ? ST_WRITE : ST_DONE;
      ST_WRITE:  state_d = ST_DONE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register.
  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Grant history and the shared read-data / merge register.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= PORT1;
      rdata_q      <= '0;
    end else begin
      if (accept) last_grant_q <= winner;
      if (state_q == ST_ACCESS && !(we_q && size_q == SZ_W)) rdata_q <= mem_rdata;
    end
  end

  // Latch the accepted request's payload.
  // NOTE: payload registers carry no reset; they are only read after an accept reloads them.
  always_ff @(posedge clk) begin
    if (accept) begin
      id_q    <= winner;
      we_q    <= req_we;
      size_q  <= req_size;
      addr_q  <= req_addr[ADDR_W+1:0];
      wdata_q <= req_wdata;
      err_q   <= !req_legal;
    end
  end

  dm_lane_merge u_lane_merge (
    .old_word (rdata_q),
    .new_data (wdata_q),
    .size     (size_q),
    .byte_off (addr_q[1:0]),
    .merged   (merged)
  );

  assign mem_addr  = addr_q[ADDR_W+1:2];
  assign mem_we    = !reset && ((state_q == ST_ACCESS && we_q && size_q == SZ_W) ||
                                (state_q == ST_WRITE));
  assign mem_wdata = (state_q == ST_WRITE) ? merged : wdata_q;

  assign done      = (state_q == ST_DONE) && !reset;
  assign p0.rvalid = done && (id_q == PORT0);
  assign p1.rvalid = done && (id_q == PORT1);
  assign p0.err    = p0.rvalid && err_q;
  assign p1.err    = p1.rvalid && err_q;
  assign p0.rdata  = rdata_q;
  assign p1.rdata  = rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed scenarios plus randomized traffic from both
// requesters, checked every cycle against a transaction-level model.
module tb_dm_arbiter;

  localparam int ADDR_W = 12;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef struct { logic we; logic [1:0] size; logic [31:0] addr; logic [31:0] wdata; } req_t;
  typedef struct { int port; int cyc; } acc_t;
  typedef struct { int port; logic err; logic [31:0] rdata; int cyc; } rv_t;
  typedef struct { logic [31:0] addr; logic [31:0] data; int cyc; } wr_t;

  logic clk = 1'b0;
  logic reset;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata, mem_rdata;
  logic [31:0]       phys    [DEPTH];
  logic [31:0]       ref_mem [DEPTH];

  dm_arbiter_if p0_bus ();
  dm_arbiter_if p1_bus ();

  dm_arbiter #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .p0        (p0_bus),
    .p1        (p1_bus),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Data memory array: asynchronous read, write at the clock edge.
  assign mem_rdata = phys[mem_addr];
  always @(posedge clk) if (mem_we) phys[mem_addr] <= mem_wdata;

  int checks   = 0;
  int failures = 0;

  req_t q0[$], q1[$];
  acc_t acc_log[$];
  rv_t  rv_log[$];
  wr_t  wr_log[$];

  // Transaction-level model state
  int          cyc = 0;
  int          next_free = 0;
  bit          pend_active = 1'b0;
  int          pend_port, pend_due, pend_wcyc, pend_idx;
  logic        pend_err;
  logic [31:0] pend_rdata, pend_wdata, pend_old;
  int          last_grant = 1;
  logic [31:0] model_rdata = '0;
  bit          rd_known = 1'b0;
  bit          rst_seen = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic req_t mk(input logic we, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata);
    req_t r;
    r.we = we; r.size = size; r.addr = addr; r.wdata = wdata;
    return r;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    int   k, off;
    k = $urandom_range(0, 9);
    r.size = (k == 0) ? 2'd3 : 2'(k % 3);
    off = $urandom_range(0, 3);
    if (r.size == 2'd2 && $urandom_range(0, 3) != 0) off = 0;
    r.addr = 32'($urandom_range(0, 15) * 4 + off);
    if ($urandom_range(0, 9) == 0) r.addr = r.addr | (32'd1 << $urandom_range(14, 31));
    r.we    = 1'($urandom_range(0, 1));
    r.wdata = $urandom;
    return r;
  endfunction

  // Model one accepted request: outcome, completion cycle and any memory write.
  task automatic accept_req(input int port, input req_t r);
    logic        legal;
    logic [31:0] old, mask, lane;
    int          sh;
    legal = (r.size != 2'd3) && !(r.size == 2'd1 && r.addr[0]) &&
            !(r.size == 2'd2 && r.addr[1:0] != 2'b00) && ((r.addr >> (ADDR_W + 2)) == 0);
    pend_active = 1'b1;
    pend_port   = port;
    pend_idx    = int'(r.addr[ADDR_W+1:2]);
    pend_wcyc   = -1;
    pend_err    = !legal;
    last_grant  = port;
    rd_known    = 1'b0;
    if (!legal) begin
      pend_due = cyc + 1;
    end else if (!r.we) begin
      pend_due    = cyc + 2;
      model_rdata = ref_mem[pend_idx];
    end else if (r.size == 2'd2) begin
      pend_due   = cyc + 2;
      pend_wcyc  = cyc + 1;
      pend_wdata = r.wdata;
      pend_old   = ref_mem[pend_idx];
      ref_mem[pend_idx] = r.wdata;
    end else begin
      pend_due    = cyc + 3;
      pend_wcyc   = cyc + 2;
      old         = ref_mem[pend_idx];
      pend_old    = old;
      model_rdata = old;
      if (r.size == 2'd0) begin
        sh   = 8 * int'(r.addr[1:0]);
        mask = 32'h0000_00FF << sh;
        lane = (r.wdata & 32'h0000_00FF) << sh;
      end else begin
        sh   = 16 * int'(r.addr[1]);
        mask = 32'h0000_FFFF << sh;
        lane = (r.wdata & 32'h0000_FFFF) << sh;
      end
      pend_wdata = (old & ~mask) | lane;
      ref_mem[pend_idx] = pend_wdata;
    end
    pend_rdata = model_rdata;
  endtask

  // Requester drivers: present the head of each queue until it is taken.
  initial begin
    p0_bus.valid = 1'b0; p0_bus.we = 1'b0; p0_bus.size = '0; p0_bus.addr = '0; p0_bus.wdata = '0;
    p1_bus.valid = 1'b0; p1_bus.we = 1'b0; p1_bus.size = '0; p1_bus.addr = '0; p1_bus.wdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (q0.size() > 0) begin
        p0_bus.valid = 1'b1; p0_bus.we = q0[0].we; p0_bus.size = q0[0].size;
        p0_bus.addr = q0[0].addr; p0_bus.wdata = q0[0].wdata;
      end else p0_bus.valid = 1'b0;
      if (q1.size() > 0) begin
        p1_bus.valid = 1'b1; p1_bus.we = q1[0].we; p1_bus.size = q1[0].size;
        p1_bus.addr = q1[0].addr; p1_bus.wdata = q1[0].wdata;
      end else p1_bus.valid = 1'b0;
    end
  end

  // Monitor: compare every cycle against the model, log observed events.
  initial begin : monitor
    bit   idle, any, due;
    int   win;
    req_t r;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        check("reset_outputs", {p0_bus.ready, p1_bus.ready, p0_bus.rvalid, p1_bus.rvalid,
                                p0_bus.err, p1_bus.err, mem_we}, 32'd0);
        if (pend_active && pend_wcyc >= cyc) ref_mem[pend_idx] = pend_old;
        pend_active = 1'b0;
        last_grant  = 1;
        model_rdata = '0;
        rd_known    = 1'b0;
        rst_seen    = 1'b1;
        next_free   = cyc + 1;
      end else begin
        if (rst_seen) begin rd_known = 1'b1; rst_seen = 1'b0; end
        idle = !pend_active && (cyc >= next_free);
        any  = p0_bus.valid || p1_bus.valid;
        win  = (p0_bus.valid && p1_bus.valid) ? ((last_grant == 1) ? 0 : 1) : (p1_bus.valid ? 1 : 0);
        check("ready0", p0_bus.ready, idle && any && win == 0);
        check("ready1", p1_bus.ready, idle && any && win == 1);
        due = pend_active && (cyc == pend_due);
        check("rvalid0", p0_bus.rvalid, due && pend_port == 0);
        check("rvalid1", p1_bus.rvalid, due && pend_port == 1);
        if (pend_active && cyc == pend_wcyc) begin
          check("mem_we", mem_we, 1);
          check("mem_addr", mem_addr, pend_idx);
          check("mem_wdata", mem_wdata, pend_wdata);
        end else begin
          check("mem_we_quiet", mem_we, 0);
        end
        if (mem_we)        wr_log.push_back('{32'(mem_addr), mem_wdata, cyc});
        if (p0_bus.rvalid) rv_log.push_back('{0, p0_bus.err, p0_bus.rdata, cyc});
        if (p1_bus.rvalid) rv_log.push_back('{1, p1_bus.err, p1_bus.rdata, cyc});
        if (due) begin
          if (pend_port == 0) begin
            check("err0", p0_bus.err, pend_err);
            check("rdata0", p0_bus.rdata, pend_rdata);
          end else begin
            check("err1", p1_bus.err, pend_err);
            check("rdata1", p1_bus.rdata, pend_rdata);
          end
          pend_active = 1'b0;
          next_free   = cyc + 1;
          rd_known    = 1'b1;
        end else if (rd_known) begin
          check("rdata_hold0", p0_bus.rdata, model_rdata);
          check("rdata_hold1", p1_bus.rdata, model_rdata);
        end
        if (p0_bus.valid && p0_bus.ready && q0.size() > 0) begin
          r = q0.pop_front();
          acc_log.push_back('{0, cyc});
          accept_req(0, r);
        end else if (p1_bus.valid && p1_bus.ready && q1.size() > 0) begin
          r = q1.pop_front();
          acc_log.push_back('{1, cyc});
          accept_req(1, r);
        end
      end
    end
  end

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || pend_active) && n < 300) begin
      @(posedge clk);
      n++;
    end
    check(tag, n < 300, 1);
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_acc(input int target);
    int n = 0;
    while (acc_log.size() <= target && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("accept_timeout", n < 50, 1);
  endtask

  initial begin : main
    int a0, r0, w0, pc;
    reset = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      phys[i]    = $urandom;
      ref_mem[i] = phys[i];
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_rdata", p0_bus.rdata, 32'd0);
    check("reset_ready", {p0_bus.ready, p1_bus.ready}, 32'd0);

    // Word store
    @(posedge clk);
    a0 = acc_log.size(); r0 = rv_log.size(); w0 = wr_log.size(); pc = cyc;
    q0.push_back(mk(1'b1, 2'd2, 32'h10, 32'hDEAD_BEEF));
    wait_idle("t1_drain");
    check("t1_counts", {8'(acc_log.size() - a0), 8'(rv_log.size() - r0), 8'(wr_log.size() - w0)}, 32'h010101);
    check("t1_first_cycle", acc_log[a0].cyc, pc + 1);
    check("t1_acc_port", acc_log[a0].port, 0);
    check("t1_wr_addr", wr_log[w0].addr, 32'd4);
    check("t1_wr_data", wr_log[w0].data, 32'hDEAD_BEEF);
    check("t1_wr_delay", wr_log[w0].cyc - acc_log[a0].cyc, 1);
    check("t1_rv", {rv_log[r0].port[0], rv_log[r0].err}, 32'd0);
    check("t1_latency", rv_log[r0].cyc - acc_log[a0].cyc, 2);

    // Byte store as read-modify-write
    a0 = acc_log.size(); r0 = rv_log.size(); w0 = wr_log.size();
    q0.push_back(mk(1'b1, 2'd0, 32'h11, 32'h0000_00AA));
    wait_idle("t2_drain");
    check("t2_counts", {8'(acc_log.size() - a0), 8'(rv_log.size() - r0), 8'(wr_log.size() - w0)}, 32'h010101);
    check("t2_wr_data", wr_log[w0].data, 32'hDEAD_AAEF);
    check("t2_wr_delay", wr_log[w0].cyc - acc_log[a0].cyc, 2);
    check("t2_latency", rv_log[r0].cyc - acc_log[a0].cyc, 3);
    check("t2_old_word", rv_log[r0].rdata, 32'hDEAD_BEEF);

    // Half store then load from port 1
    a0 = acc_log.size(); r0 = rv_log.size(); w0 = wr_log.size();
    q1.push_back(mk(1'b1, 2'd1, 32'h12, 32'h0000_1234));
    q1.push_back(mk(1'b0, 2'd2, 32'h10, 32'h0));
    wait_idle("t3_drain");
    check("t3_counts", {8'(acc_log.size() - a0), 8'(rv_log.size() - r0), 8'(wr_log.size() - w0)}, 32'h020201);
    check("t3_wr_data", wr_log[w0].data, 32'h1234_AAEF);
    check("t3_load_port", rv_log[r0 + 1].port, 1);
    check("t3_load_err", rv_log[r0 + 1].err, 0);
    check("t3_load_rdata", rv_log[r0 + 1].rdata, 32'h1234_AAEF);

    // Both ports valid continuously: strict alternation
    a0 = acc_log.size();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(mk(1'b0, 2'd2, 32'(4 * i), 32'h0));
      q1.push_back(mk(1'b1, 2'd2, 32'(32 + 4 * i), $urandom));
    end
    wait_idle("t4_drain");
    check("t4_count", acc_log.size() - a0, 6);
    for (int i = 0; i < 6; i++) check("t4_order", acc_log[a0 + i].port, i % 2);
    for (int i = 0; i < 5; i++) check("t4_spacing", acc_log[a0 + i + 1].cyc - acc_log[a0 + i].cyc, 3);

    // Illegal requests: misaligned half, out-of-range load
    a0 = acc_log.size(); r0 = rv_log.size(); w0 = wr_log.size();
    q0.push_back(mk(1'b1, 2'd1, 32'h13, 32'h0000_5678));
    wait_idle("t5a_drain");
    q1.push_back(mk(1'b0, 2'd2, 32'h0001_0000, 32'h0));
    wait_idle("t5b_drain");
    check("t5_counts", {8'(acc_log.size() - a0), 8'(rv_log.size() - r0), 8'(wr_log.size() - w0)}, 32'h020200);
    check("t5_err0", {rv_log[r0].port[0], rv_log[r0].err}, 32'd1);
    check("t5_lat0", rv_log[r0].cyc - acc_log[a0].cyc, 1);
    check("t5_err1", {rv_log[r0 + 1].port[0], rv_log[r0 + 1].err}, 32'd3);
    check("t5_lat1", rv_log[r0 + 1].cyc - acc_log[a0 + 1].cyc, 1);

    // Reset during the write phase of a byte store
    a0 = acc_log.size(); r0 = rv_log.size(); w0 = wr_log.size();
    q0.push_back(mk(1'b1, 2'd0, 32'h10, 32'h0000_0055));
    wait_acc(a0);
    #1;
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    check("t6_no_write", wr_log.size() - w0, 0);
    check("t6_no_rvalid", rv_log.size() - r0, 0);
    check("t6_word_kept", phys[4], 32'h1234_AAEF);
    a0 = acc_log.size(); r0 = rv_log.size();
    q0.push_back(mk(1'b1, 2'd0, 32'h10, 32'h0000_0055));
    q1.push_back(mk(1'b0, 2'd2, 32'h10, 32'h0));
    wait_idle("t6_drain");
    check("t6_count", acc_log.size() - a0, 2);
    check("t6_tie_first", acc_log[a0].port, 0);
    check("t6_load", rv_log[r0 + 1].rdata, 32'h1234_AA55);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      if (q0.size() < 2 && $urandom_range(0, 2) == 0) q0.push_back(rand_req());
      if (q1.size() < 2 && $urandom_range(0, 2) == 0) q1.push_back(rand_req());
      if ($urandom_range(0, 299) == 0) begin
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
      end
    end
    wait_idle("rand_drain");
    for (int i = 0; i < 16; i++) check("final_mem", phys[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    failures++;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
